// File: rtl/fifo_drain_arbiter_pkg.sv
// fifo_drain_arbiter_pkg: flit/word widths and drain FSM state encoding shared by the arbiter files
package fifo_drain_arbiter_pkg;
  localparam int FlitWidth = 82;
  localparam int ChildrenWidth = 3;
  localparam int ValidBitPos = FlitWidth - 1;
  localparam int WordWidth = FlitWidth + ChildrenWidth;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;
endpackage

// File: rtl/fifo_drain_arbiter_rr_pick.sv
// fifo_drain_arbiter_rr_pick: first set req bit searching upward from ptr with wrap; ports req/ptr in, found/sel out
module fifo_drain_arbiter_rr_pick #(
  parameter int N = 4,
  parameter int LG = 2
) (
  input  logic [N-1:0]  req,
  input  logic [LG-1:0] ptr,
  output logic          found,
  output logic [LG-1:0] sel
);
  always_comb begin
    found = |req;
    sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) sel = LG'((int'(ptr) + i) % N);
    end
  end
endmodule

// File: rtl/fifo_drain_arbiter.sv
// fifo_drain_arbiter: round-robin drain of NumPorts 1-cycle-read FIFOs onto one valid/ready channel; ports clk, rst, fifo_empty/fifo_data in, fifo_rd_en out, out_data/out_port/out_valid out, out_ready in, busy out
module fifo_drain_arbiter
  import fifo_drain_arbiter_pkg::*;
#(
  parameter int NumPorts = 4,
  parameter int lg_numports = 2,
  parameter int FlitWidth = fifo_drain_arbiter_pkg::FlitWidth,
  parameter int ChildrenWidth = fifo_drain_arbiter_pkg::ChildrenWidth,
  parameter int WordWidth = FlitWidth + ChildrenWidth
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NumPorts-1:0]           fifo_empty,
  input  logic [NumPorts*WordWidth-1:0] fifo_data,
  output logic [NumPorts-1:0]           fifo_rd_en,
  output logic [WordWidth-1:0]          out_data,
  output logic [lg_numports-1:0]        out_port,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy
);
  state_t state, state_nxt;
  logic [lg_numports-1:0] grant, rr_ptr, sel;
  logic found, issue;
  logic [WordWidth-1:0] word;
  fifo_drain_arbiter_rr_pick #(.N(NumPorts), .LG(lg_numports)) u_pick (
    .req(~fifo_empty),
    .ptr(rr_ptr),
    .found(found),
    .sel(sel)
  );
  assign word = fifo_data[int'(grant)*WordWidth +: WordWidth];
  assign busy = state != IDLE;
  always_comb begin
    issue = !rst && found && (state == IDLE || (state == HOLD && out_ready));
    fifo_rd_en = issue ? NumPorts'(1) << sel : '0;
    state_nxt = issue ? FETCH
              : state == FETCH ? (word[FlitWidth-1] ? HOLD : IDLE)
              : (state == HOLD && out_ready) ? IDLE
              : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      rr_ptr <= '0;
      out_data <= '0;
      out_port <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (issue) grant <= sel;
      if (state == FETCH) begin
        rr_ptr <= (int'(grant) == NumPorts - 1) ? '0 : grant + 1'b1;
        if (word[FlitWidth-1]) begin
          out_data <= word;
          out_port <= grant;
          out_valid <= 1'b1;
        end
      end
      if (state == HOLD && out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// tb_fifo_drain_arbiter: directed scoreboard bench for fifo_drain_arbiter with a registered-read FIFO model
module tb_fifo_drain_arbiter;
  import fifo_drain_arbiter_pkg::*;
  localparam int N = 4;
  localparam int W = WordWidth;
  localparam int F = FlitWidth;
  typedef struct {int port; logic [W-1:0] word;} exp_t;
  typedef struct {int port; int cyc;} grant_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] fifo_empty;
  logic [N*W-1:0] fifo_data;
  logic [N-1:0] fifo_rd_en;
  logic [W-1:0] out_data;
  logic [1:0] out_port;
  logic out_valid;
  logic out_ready = 1'b1;
  logic busy;
  logic [W-1:0] fdata [N] = '{default: '0};
  logic [W-1:0] mem [N][32];
  int wr [N] = '{default: 0};
  int rd [N] = '{default: 0};
  exp_t sb[$];
  grant_t glog[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = 0;
  always #5 clk = ~clk;
  fifo_drain_arbiter dut (
    .clk(clk),
    .rst(rst),
    .fifo_empty(fifo_empty),
    .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .out_data(out_data),
    .out_port(out_port),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy)
  );
  for (genvar g = 0; g < N; g++) begin : g_fifo
    assign fifo_data[g*W +: W] = fdata[g];
    assign fifo_empty[g] = wr[g] == rd[g];
  end
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int p = 0; p < N; p++) begin
      if (fifo_rd_en[p] && rd[p] < wr[p]) begin
        fdata[p] <= mem[p][rd[p]];
        rd[p] <= rd[p] + 1;
      end
    end
  end
  always @(negedge clk) begin
    if (fifo_rd_en != '0) begin
      checks++;
      if (!$onehot(fifo_rd_en) || (fifo_rd_en & fifo_empty) != '0) begin
        errors++;
        $display("FAIL rd_en legality: rd_en=%b empty=%b", fifo_rd_en, fifo_empty);
      end
      for (int p = 0; p < N; p++) if (fifo_rd_en[p]) glog.push_back('{p, cyc});
    end
    if (out_valid && out_ready && !rst) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected output: port=%0d data=%0h, expected nothing", out_port, out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (int'(out_port) != e.port || out_data !== e.word) begin
          errors++;
          $display("FAIL output word: got port=%0d data=%0h expected port=%0d data=%0h", out_port, out_data, e.port, e.word);
        end
      end
    end
  end
  function automatic logic [W-1:0] mk(input logic v, input logic [2:0] ch, input logic [31:0] pl);
    return {ch, v, {(F - 33){1'b0}}, pl};
  endfunction
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input int p, input logic [W-1:0] w);
    mem[p][wr[p]] = w;
    wr[p] = wr[p] + 1;
  endtask
  task automatic expect_out(input int p, input logic [W-1:0] w);
    sb.push_back('{p, w});
  endtask
  task automatic expect_grant(input int p, input int gap);
    grant_t g;
    if (glog.size() == 0) begin
      chk("grant present", 0, 1);
    end else begin
      g = glog.pop_front();
      chk("grant port", g.port, p);
      if (gap > 0) chk("grant spacing", g.cyc - last_cyc, gap);
      last_cyc = g.cyc;
    end
  endtask
  task automatic wait_idle();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(!busy && !out_valid && &fifo_empty) && n < 60);
    chk("idle reached", n < 60, 1);
  endtask
  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [W-1:0] hd;
    logic [1:0] hp;
    int n;
    tick();
    tick();
    chk("reset rd_en", fifo_rd_en, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_port", out_port, 0);
    chk("reset busy", busy, 0);
    rst = 1'b0;
    push(2, mk(1'b1, 3'd5, 32'h0000_00A5));
    expect_out(2, mk(1'b1, 3'd5, 32'h0000_00A5));
    @(negedge clk);
    chk("single rd_en", fifo_rd_en, 4'b0100);
    @(negedge clk);
    chk("single fetch busy", busy, 1);
    chk("single fetch not valid", out_valid, 0);
    @(negedge clk);
    chk("single valid", out_valid, 1);
    chk("single port", out_port, 2);
    chk("single payload", out_data[31:0], 32'hA5);
    chk("single children", out_data[W-1 -: 3], 3'd5);
    @(negedge clk);
    chk("single back idle", busy, 0);
    expect_grant(2, 0);
    do_reset();
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < N; p++) begin
        push(p, mk(1'b1, 3'(p), 32'h100 * k + p));
        expect_out(p, mk(1'b1, 3'(p), 32'h100 * k + p));
      end
    end
    wait_idle();
    for (int k = 0; k < 2; k++) for (int p = 0; p < N; p++) expect_grant(p, (k == 0 && p == 0) ? 0 : 2);
    out_ready = 1'b0;
    push(0, mk(1'b1, 3'd1, 32'hBEEF_0000));
    expect_out(0, mk(1'b1, 3'd1, 32'hBEEF_0000));
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("backpressure hold reached", out_valid, 1);
    push(1, mk(1'b1, 3'd2, 32'hBEEF_0001));
    expect_out(1, mk(1'b1, 3'd2, 32'hBEEF_0001));
    hd = out_data;
    hp = out_port;
    chk("backpressure held port", hp, 0);
    repeat (5) begin
      @(negedge clk);
      chk("backpressure data stable", out_data, hd);
      chk("backpressure port stable", out_port, hp);
      chk("backpressure no rd_en", fifo_rd_en, 0);
      chk("backpressure valid held", out_valid, 1);
    end
    tick();
    out_ready = 1'b1;
    wait_idle();
    expect_grant(0, 0);
    expect_grant(1, 0);
    do_reset();
    push(1, mk(1'b0, 3'd7, 32'hDEAD_DEAD));
    push(1, mk(1'b1, 3'd3, 32'h0000_0041));
    push(3, mk(1'b1, 3'd4, 32'h0000_0043));
    expect_out(3, mk(1'b1, 3'd4, 32'h0000_0043));
    expect_out(1, mk(1'b1, 3'd3, 32'h0000_0041));
    wait_idle();
    expect_grant(1, 0);
    expect_grant(3, 0);
    expect_grant(1, 0);
    do_reset();
    push(2, mk(1'b1, 3'd0, 32'h0000_0051));
    expect_out(2, mk(1'b1, 3'd0, 32'h0000_0051));
    wait_idle();
    push(1, mk(1'b1, 3'd0, 32'h0000_0052));
    expect_out(1, mk(1'b1, 3'd0, 32'h0000_0052));
    wait_idle();
    push(1, mk(1'b1, 3'd6, 32'h0000_0053));
    push(2, mk(1'b1, 3'd6, 32'h0000_0054));
    expect_out(2, mk(1'b1, 3'd6, 32'h0000_0054));
    expect_out(1, mk(1'b1, 3'd6, 32'h0000_0053));
    wait_idle();
    expect_grant(2, 0);
    expect_grant(1, 0);
    expect_grant(2, 0);
    expect_grant(1, 0);
    do_reset();
    push(0, mk(1'b1, 3'd7, 32'h0BAD_0BAD));
    @(negedge clk);
    chk("reset-fetch rd_en", fifo_rd_en, 4'b0001);
    tick();
    chk("reset-fetch in fetch", busy, 1);
    rst = 1'b1;
    #1;
    chk("reset-fetch busy", busy, 0);
    chk("reset-fetch out_valid", out_valid, 0);
    chk("reset-fetch rd_en cleared", fifo_rd_en, 0);
    tick();
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("reset-fetch word dropped", out_valid, 0);
    end
    chk("reset-fetch idle", busy, 0);
    expect_grant(0, 0);
    chk("scoreboard drained", sb.size(), 0);
    chk("grant log drained", glog.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
